// File: rtl/axi_stream_strip_header_if.sv
// Stream, strip-count and header signals of the header strip stage.
// Optional error outputs exist only when AXIS_STRIP_ERR_EN is defined.
interface axi_stream_strip_header_if #(
   parameter int DATA_WD = 32
) ();
   localparam int NB = DATA_WD / 8;
   localparam int CW = $clog2(NB) + 1;

   logic              valid_in;
   logic [DATA_WD-1:0] data_in;
   logic [NB-1:0]      keep_in;
   logic              last_in;
   logic              ready_in;
   logic              valid_out;
   logic [DATA_WD-1:0] data_out;
   logic [NB-1:0]      keep_out;
   logic              last_out;
   logic              ready_out;
   logic              valid_strip;
   logic [CW-1:0]      strip_cnt;
   logic              ready_strip;
   logic              hdr_valid;
   logic [DATA_WD-1:0] hdr_data;
   logic [NB-1:0]      hdr_keep;
`ifdef AXIS_STRIP_ERR_EN
   logic              err_short;
   logic [15:0]        err_cnt;
`endif

   modport slave (
      input  valid_in, data_in, keep_in, last_in,
      input  ready_out, valid_strip, strip_cnt,
      output ready_in, valid_out, data_out,
      output keep_out, last_out, ready_strip,
      output hdr_valid, hdr_data, hdr_keep
`ifdef AXIS_STRIP_ERR_EN
      , output err_short, err_cnt
`endif
   );

   modport master (
      output valid_in, data_in, keep_in, last_in,
      output ready_out, valid_strip, strip_cnt,
      input  ready_in, valid_out, data_out,
      input  keep_out, last_out, ready_strip,
      input  hdr_valid, hdr_data, hdr_keep
`ifdef AXIS_STRIP_ERR_EN
      , input err_short, err_cnt
`endif
   );
endinterface

// File: rtl/axi_stream_strip_header.sv
// Strips the first S bytes of each AXI Stream packet onto a header port and
// realigns the payload MSB-first. AXIS_STRIP_ERR_EN adds short-packet errors.
module axi_stream_strip_header #(
   parameter int DATA_WD      = 32,
   parameter int DATA_BYTE_WD = DATA_WD / 8,
   parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
   input logic clk,
   input logic rst_n,
   axi_stream_strip_header_if.slave s
);
   localparam int N  = DATA_BYTE_WD;
   localparam int CW = BYTE_CNT_WD + 1;
   localparam logic [CW-1:0] NB = CW'(N);

   typedef enum logic [1:0] {IDLE, FIRST, STREAM, FLUSH} state_t;

   function automatic logic [DATA_WD-1:0] bmask(input logic [N-1:0] kp);
      for (int i = 0; i < N; i++) bmask[8*i +: 8] = {8{kp[i]}};
   endfunction

   function automatic logic [CW-1:0] popcnt(input logic [N-1:0] kp);
      popcnt = '0;
      for (int i = 0; i < N; i++) popcnt = popcnt + CW'(kp[i]);
   endfunction

   function automatic logic [N-1:0] ones(input logic [CW-1:0] n);
      ones = ~({N{1'b1}} >> n);
   endfunction

   state_t state_q, state_d;
   logic [CW-1:0]      s_q, s_d;
   logic [CW-1:0]      r_q, r_d;
   logic [DATA_WD-1:0] res_q, res_d;
   logic              vout_q, vout_d;
   logic [DATA_WD-1:0] dout_q, dout_d;
   logic [N-1:0]       kout_q, kout_d;
   logic              lout_q, lout_d;
   logic              hv_q, hv_d;
   logic [DATA_WD-1:0] hd_q, hd_d;
   logic [N-1:0]       hk_q, hk_d;
`ifdef AXIS_STRIP_ERR_EN
   logic              err_q, err_d;
   logic [15:0]        ecnt_q, ecnt_d;
`endif

   logic              can_out;
   logic              acc;
   logic [CW-1:0]      k;
   logic [CW-1:0]      kh;
   logic [CW:0]        sum;
   logic [CW:0]        diff;
   logic [DATA_WD-1:0] din;

   assign can_out       = !vout_q || s.ready_out;
   assign s.ready_in    = (state_q == FIRST || state_q == STREAM) && can_out;
   assign s.ready_strip = (state_q == IDLE);
   assign acc           = s.valid_in && s.ready_in;
   assign k             = popcnt(s.keep_in);
   assign kh            = (k < s_q) ? k : s_q;
   assign din           = s.data_in & bmask(s.keep_in);
   assign sum           = {1'b0, r_q} + {1'b0, k};
   assign diff          = sum - {1'b0, NB};

   assign s.valid_out = vout_q;
   assign s.data_out  = dout_q;
   assign s.keep_out  = kout_q;
   assign s.last_out  = lout_q;
   assign s.hdr_valid = hv_q;
   assign s.hdr_data  = hd_q;
   assign s.hdr_keep  = hk_q;
`ifdef AXIS_STRIP_ERR_EN
   assign s.err_short = err_q;
   assign s.err_cnt   = ecnt_q;
`endif

   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      r_d     = r_q;
      res_d   = res_q;
      vout_d  = vout_q;
      dout_d  = dout_q;
      kout_d  = kout_q;
      lout_d  = lout_q;
      hv_d    = 1'b0;
      hd_d    = hd_q;
      hk_d    = hk_q;
`ifdef AXIS_STRIP_ERR_EN
      err_d   = 1'b0;
      ecnt_d  = ecnt_q;
`endif
      // a free register drops its beat unless reloaded below
      if (can_out) begin
         vout_d = 1'b0;
         dout_d = '0;
         kout_d = '0;
         lout_d = 1'b0;
      end
      unique case (state_q)
         IDLE: begin
            if (s.valid_strip) begin
               s_d     = (s.strip_cnt > NB) ? NB : s.strip_cnt;
               state_d = FIRST;
            end
         end
         FIRST: begin
            if (acc) begin
               hv_d  = 1'b1;
               hk_d  = ones(kh);
               hd_d  = din & bmask(ones(kh));
               res_d = din << {s_q, 3'b000};
               r_d   = (k > s_q) ? k - s_q : '0;
`ifdef AXIS_STRIP_ERR_EN
               err_d = s.last_in && (k < s_q);
               if (err_d && ecnt_q != 16'hffff) ecnt_d = ecnt_q + 16'd1;
`endif
               if (!s.last_in) state_d = STREAM;
               else if (k > s_q) state_d = FLUSH;
               else state_d = IDLE;
            end
         end
         STREAM: begin
            if (acc) begin
               vout_d = 1'b1;
               dout_d = res_q | (din >> {r_q, 3'b000});
               kout_d = '1;
               lout_d = 1'b0;
               res_d  = din << {NB - r_q, 3'b000};
               if (s.last_in) begin
                  if (sum <= {1'b0, NB}) begin
                     kout_d  = ones(sum[CW-1:0]);
                     lout_d  = 1'b1;
                     r_d     = '0;
                     res_d   = '0;
                     state_d = IDLE;
                  end else begin
                     r_d     = diff[CW-1:0];
                     state_d = FLUSH;
                  end
               end
            end
         end
         FLUSH: begin
            if (can_out) begin
               vout_d  = 1'b1;
               dout_d  = res_q;
               kout_d  = ones(r_q);
               lout_d  = 1'b1;
               r_d     = '0;
               res_d   = '0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         s_q     <= '0;
         r_q     <= '0;
         res_q   <= '0;
         vout_q  <= 1'b0;
         dout_q  <= '0;
         kout_q  <= '0;
         lout_q  <= 1'b0;
         hv_q    <= 1'b0;
         hd_q    <= '0;
         hk_q    <= '0;
`ifdef AXIS_STRIP_ERR_EN
         err_q   <= 1'b0;
         ecnt_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         r_q     <= r_d;
         res_q   <= res_d;
         vout_q  <= vout_d;
         dout_q  <= dout_d;
         kout_q  <= kout_d;
         lout_q  <= lout_d;
         hv_q    <= hv_d;
         hd_q    <= hd_d;
         hk_q    <= hk_d;
`ifdef AXIS_STRIP_ERR_EN
         err_q   <= err_d;
         ecnt_q  <= ecnt_d;
`endif
      end
   end
endmodule

// File: tb/tb_axi_stream_strip_header.sv
// Directed bench for axi_stream_strip_header with N=4.
// Output beats and header pulses are collected and compared per packet.
module tb_axi_stream_strip_header;
   logic clk;
   logic rst_n;
   int   checks = 0;
   int   failures = 0;

   logic [63:0] out_q[$];
   logic [63:0] hdr_q[$];
   logic [63:0] exp_q[$];

   axi_stream_strip_header_if #(.DATA_WD(32)) bus ();

   axi_stream_strip_header #(.DATA_WD(32)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .s    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.valid_out && bus.ready_out)
         out_q.push_back({27'd0, bus.data_out, bus.keep_out, bus.last_out});
      if (bus.hdr_valid)
         hdr_q.push_back({28'd0, bus.hdr_data, bus.hdr_keep});
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] pk(input logic [31:0] d,
                                      input logic [3:0] k, input logic l);
      pk = {27'd0, d, k, l};
   endfunction

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_strip(input logic [2:0] sc);
      int t = 0;
      bus.valid_strip = 1'b1;
      bus.strip_cnt   = sc;
      do begin
         @(negedge clk);
         t++;
      end while (!bus.ready_strip && t < 50);
      if (!bus.ready_strip) chk("strip_timeout", 64'd0, 64'd1);
      @(posedge clk);
      #1;
      bus.valid_strip = 1'b0;
   endtask

   task automatic send_beat(input logic [31:0] d, input logic [3:0] k,
                            input logic l);
      int t = 0;
      bus.valid_in = 1'b1;
      bus.data_in  = d;
      bus.keep_in  = k;
      bus.last_in  = l;
      do begin
         @(negedge clk);
         t++;
      end while (!bus.ready_in && t < 50);
      if (!bus.ready_in) chk("beat_timeout", 64'd0, 64'd1);
      @(posedge clk);
      #1;
      bus.valid_in = 1'b0;
      bus.last_in  = 1'b0;
   endtask

   task automatic cmp_outs(input string tag);
      chk({tag, ".nbeats"}, 64'(out_q.size()), 64'(exp_q.size()));
      foreach (exp_q[i])
         if (i < out_q.size())
            chk($sformatf("%s.beat%0d", tag, i), out_q[i], exp_q[i]);
      out_q.delete();
      exp_q.delete();
   endtask

   task automatic cmp_hdr(input string tag, input logic [31:0] d,
                          input logic [3:0] k);
      chk({tag, ".nhdr"}, 64'(hdr_q.size()), 64'd1);
      if (hdr_q.size() > 0) chk({tag, ".hdr"}, hdr_q[0], {28'd0, d, k});
      hdr_q.delete();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n           = 1'b0;
      bus.valid_in    = 1'b0;
      bus.data_in     = '0;
      bus.keep_in     = '0;
      bus.last_in     = 1'b0;
      bus.ready_out   = 1'b1;
      bus.valid_strip = 1'b0;
      bus.strip_cnt   = '0;
      repeat (2) @(negedge clk);
      chk("rst.valid_out", 64'(bus.valid_out), 64'd0);
      chk("rst.data_out", 64'(bus.data_out), 64'd0);
      chk("rst.ready_in", 64'(bus.ready_in), 64'd0);
      chk("rst.ready_strip", 64'(bus.ready_strip), 64'd1);
      chk("rst.hdr_valid", 64'(bus.hdr_valid), 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(2);

      // S=2, three beats, last partial
      send_strip(3'd2);
      send_beat(32'hAABBCCDD, 4'hF, 1'b0);
      chk("c1.busy_strip", 64'(bus.ready_strip), 64'd0);
      send_beat(32'h11223344, 4'hF, 1'b0);
      send_beat(32'h55667788, 4'hC, 1'b1);
      idle(5);
      cmp_hdr("c1", 32'hAABB0000, 4'hC);
      exp_q.push_back(pk(32'hCCDD1122, 4'hF, 1'b0));
      exp_q.push_back(pk(32'h33445566, 4'hF, 1'b1));
      cmp_outs("c1");

      // S=1, residue spills into a flush beat
      send_strip(3'd1);
      send_beat(32'hAABBCCDD, 4'hF, 1'b0);
      send_beat(32'h11223344, 4'hF, 1'b1);
      chk("c2.ready_in_flush", 64'(bus.ready_in), 64'd0);
      idle(5);
      cmp_hdr("c2", 32'hAA000000, 4'h8);
      exp_q.push_back(pk(32'hBBCCDD11, 4'hF, 1'b0));
      exp_q.push_back(pk(32'h22334400, 4'hE, 1'b1));
      cmp_outs("c2");

      // S=4, whole first beat is header
      send_strip(3'd4);
      send_beat(32'hAABBCCDD, 4'hF, 1'b0);
      send_beat(32'h11223344, 4'hE, 1'b1);
      idle(5);
      cmp_hdr("c3", 32'hAABBCCDD, 4'hF);
      exp_q.push_back(pk(32'h11223300, 4'hE, 1'b1));
      cmp_outs("c3");

      // strip count above N clamps to N
      send_strip(3'd6);
      send_beat(32'h01020304, 4'hF, 1'b0);
      send_beat(32'h0A0B0C0D, 4'hF, 1'b1);
      idle(5);
      cmp_hdr("clamp", 32'h01020304, 4'hF);
      exp_q.push_back(pk(32'h0A0B0C0D, 4'hF, 1'b1));
      cmp_outs("clamp");

      // S=3, packet shorter than its header
      send_strip(3'd3);
      send_beat(32'hAABBCCDD, 4'hC, 1'b1);
      chk("c4.ready_strip", 64'(bus.ready_strip), 64'd1);
`ifdef AXIS_STRIP_ERR_EN
      chk("c4.err_short", 64'(bus.err_short), 64'd1);
      idle(1);
      chk("c4.err_short_off", 64'(bus.err_short), 64'd0);
      chk("c4.err_cnt", 64'(bus.err_cnt), 64'd1);
`endif
      idle(5);
      cmp_hdr("c4", 32'hAABB0000, 4'hC);
      cmp_outs("c4");

      // case 1 again with downstream stalled after the first output
      bus.ready_out = 1'b0;
      fork
         begin
            send_strip(3'd2);
            send_beat(32'hAABBCCDD, 4'hF, 1'b0);
            send_beat(32'h11223344, 4'hF, 1'b0);
            send_beat(32'h55667788, 4'hC, 1'b1);
         end
         begin
            int t = 0;
            do begin
               @(negedge clk);
               t++;
            end while (!bus.valid_out && t < 100);
            chk("c5.first_valid", 64'(bus.valid_out), 64'd1);
            for (int i = 0; i < 3; i++) begin
               @(negedge clk);
               chk($sformatf("c5.hold_data%0d", i),
                   64'(bus.data_out), 64'h00000000CCDD1122);
               chk($sformatf("c5.hold_valid%0d", i),
                   64'(bus.valid_out), 64'd1);
               chk($sformatf("c5.hold_rdy%0d", i),
                   64'(bus.ready_in), 64'd0);
            end
            @(posedge clk);
            #1;
            bus.ready_out = 1'b1;
         end
      join
      idle(5);
      cmp_hdr("c5", 32'hAABB0000, 4'hC);
      exp_q.push_back(pk(32'hCCDD1122, 4'hF, 1'b0));
      exp_q.push_back(pk(32'h33445566, 4'hF, 1'b1));
      cmp_outs("c5");

      // reset mid-packet in STREAM with r=2, then S=0 pass-through
      send_strip(3'd2);
      send_beat(32'hAABBCCDD, 4'hF, 1'b0);
      send_beat(32'h11223344, 4'hF, 1'b0);
      #1;
      rst_n = 1'b0;
      #1;
      chk("c6.valid_out", 64'(bus.valid_out), 64'd0);
      chk("c6.data_out", 64'(bus.data_out), 64'd0);
      chk("c6.keep_out", 64'(bus.keep_out), 64'd0);
      chk("c6.ready_strip", 64'(bus.ready_strip), 64'd1);
      idle(2);
      rst_n = 1'b1;
      out_q.delete();
      hdr_q.delete();
      idle(2);
      cmp_outs("c6.quiet");
      send_strip(3'd0);
      send_beat(32'h01020304, 4'hF, 1'b0);
      send_beat(32'h05060708, 4'h8, 1'b1);
      idle(5);
      cmp_hdr("c6", 32'h00000000, 4'h0);
      exp_q.push_back(pk(32'h01020304, 4'hF, 1'b0));
      exp_q.push_back(pk(32'h05000000, 4'h8, 1'b1));
      cmp_outs("c6");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
